// File: rtl/load_store_unit_if.sv
// Request and data-memory bus of the load/store unit.
// The slave modport is the unit itself; the master modport is the requester/memory side.
interface load_store_unit_if;
   logic        req;
   logic        write;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic        MemoryRead;
   logic        MemoryWrite;
   logic [31:0] MemoryAddress;
   logic [31:0] MemoryWriteData;
   logic [31:0] MemoryReadData;

   modport slave (
      input  req, write, op, addr, wdata, MemoryReadData,
      output busy, done, err, rdata,
      output MemoryRead, MemoryWrite, MemoryAddress, MemoryWriteData
   );

   modport master (
      output req, write, op, addr, wdata, MemoryReadData,
      input  busy, done, err, rdata,
      input  MemoryRead, MemoryWrite, MemoryAddress, MemoryWriteData
   );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a big-endian byte-addressed memory; done after 1 (error),
// RD_LAT+1 (load), 2 (word store) or RD_LAT+2 (sub-word store) edges; requests are ignored while busy.
module load_store_unit #(
   parameter int unsigned DM_SIZE = 1024,
   parameter int unsigned RD_LAT  = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   load_store_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  lat_cnt;
   logic        lat_last;

   logic        write_q;
   logic        uns_q;
   logic        err_q;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic [15:0] wdata_q;
   logic [31:0] rdata_q;
   logic [31:0] maddr_q;
   logic [31:0] mwdata_q;

   logic [31:0] waddr;
   logic [32:0] last_byte;
   logic        req_bad;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_val;
   logic [31:0] merge_val;

   assign waddr     = {bus.addr[31:2], 2'b00};
   assign last_byte = {1'b0, waddr} + 33'd3;
   assign lat_last  = (lat_cnt == 4'(RD_LAT - 1));

   // Rejection is decided from the raw request so the error path never touches memory.
   always_comb begin
      req_bad = 1'b0;
      if (bus.op == 3'd3 || bus.op == 3'd6 || bus.op == 3'd7)
         req_bad = 1'b1;
      if (bus.op[1:0] == 2'd1 && bus.addr[0])
         req_bad = 1'b1;
      if (bus.op[1:0] == 2'd2 && bus.addr[1:0] != 2'b00)
         req_bad = 1'b1;
      if (last_byte >= 33'(DM_SIZE))
         req_bad = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.req) begin
               if (req_bad)
                  state_nxt = DONE;
               else if (bus.write && bus.op[1:0] == 2'd2)
                  state_nxt = WRITE;
               else
                  state_nxt = READ;
            end
         end
         READ: begin
            if (lat_last)
               state_nxt = write_q ? WRITE : DONE;
         end
         WRITE:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy        = (state != IDLE);
      bus.done        = (state == DONE);
      bus.err         = (state == DONE) && err_q;
      bus.MemoryRead  = (state == READ);
      bus.MemoryWrite = (state == WRITE);
   end

   assign bus.rdata           = rdata_q;
   assign bus.MemoryAddress   = maddr_q;
   assign bus.MemoryWriteData = mwdata_q;

   always_ff @(posedge clock) begin
      if (!reset_n)
         lat_cnt <= 4'd0;
      else if (state == READ && !lat_last)
         lat_cnt <= lat_cnt + 4'd1;
      else
         lat_cnt <= 4'd0;
   end

   // Lane 0 is the most significant byte of the memory word.
   always_comb begin
      lane_b = 8'd0;
      unique case (off_q)
         2'd0: lane_b = bus.MemoryReadData[31:24];
         2'd1: lane_b = bus.MemoryReadData[23:16];
         2'd2: lane_b = bus.MemoryReadData[15:8];
         2'd3: lane_b = bus.MemoryReadData[7:0];
      endcase
      lane_h = off_q[1] ? bus.MemoryReadData[15:0] : bus.MemoryReadData[31:16];

      load_val = bus.MemoryReadData;
      if (size_q == 2'd0)
         load_val = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      else if (size_q == 2'd1)
         load_val = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
   end

   always_comb begin
      merge_val = bus.MemoryReadData;
      if (size_q == 2'd0) begin
         unique case (off_q)
            2'd0: merge_val[31:24] = wdata_q[7:0];
            2'd1: merge_val[23:16] = wdata_q[7:0];
            2'd2: merge_val[15:8]  = wdata_q[7:0];
            2'd3: merge_val[7:0]   = wdata_q[7:0];
         endcase
      end else if (off_q[1]) begin
         merge_val[15:0] = wdata_q;
      end else begin
         merge_val[31:16] = wdata_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         write_q  <= 1'b0;
         uns_q    <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= 2'd0;
         off_q    <= 2'd0;
         wdata_q  <= 16'd0;
         rdata_q  <= 32'd0;
         maddr_q  <= 32'd0;
         mwdata_q <= 32'd0;
      end else begin
         if (state == IDLE && bus.req) begin
            write_q <= bus.write;
            uns_q   <= bus.op[2];
            err_q   <= req_bad;
            size_q  <= bus.op[1:0];
            off_q   <= bus.addr[1:0];
            wdata_q <= bus.wdata[15:0];
            if (!req_bad) begin
               maddr_q  <= waddr;
               mwdata_q <= bus.wdata;
            end
         end
         // Sub-word stores reuse the read beat to build the word that WRITE puts on the bus.
         if (state == READ && lat_last) begin
            if (write_q)
               mwdata_q <= merge_val;
            else
               rdata_q <= load_val;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Drives two load/store units (RD_LAT 1 and 3) against a shared byte memory and
// compares every completion with a byte-level reference model.
module tb_load_store_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req, write, sel, load_en;
   logic [2:0]  op;
   logic [31:0] addr, wdata;

   logic [7:0]  mem     [0:1023];
   logic [7:0]  ref_mem [0:1023];
   logic [31:0] exp_rdata [0:1];

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          done_edge;
      logic        err;
      logic [31:0] rdata;
      int          rdc;
      int          wrc;
      int          both;
      int          addr_bad;
      int          busy_bad;
      logic [31:0] wdat;
   } obs_t;
   obs_t ob;

   logic        x_err;
   int          x_edge, x_rdc, x_wrc;
   logic [31:0] x_val;

   load_store_unit_if bus1 ();
   load_store_unit_if bus3 ();

   load_store_unit #(.DM_SIZE(1024), .RD_LAT(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .bus(bus1.slave));
   load_store_unit #(.DM_SIZE(1024), .RD_LAT(3)) dut3 (
      .clock(clock), .reset_n(reset_n), .bus(bus3.slave));

   always #5 clock = ~clock;

   logic [9:0] a1, a3;
   assign a1 = bus1.MemoryAddress[9:0];
   assign a3 = bus3.MemoryAddress[9:0];

   assign bus1.req   = req & ~sel;
   assign bus3.req   = req & sel;
   assign bus1.write = write;
   assign bus3.write = write;
   assign bus1.op    = op;
   assign bus3.op    = op;
   assign bus1.addr  = addr;
   assign bus3.addr  = addr;
   assign bus1.wdata = wdata;
   assign bus3.wdata = wdata;
   assign bus1.MemoryReadData = {mem[a1], mem[a1 + 10'd1], mem[a1 + 10'd2], mem[a1 + 10'd3]};
   assign bus3.MemoryReadData = {mem[a3], mem[a3 + 10'd1], mem[a3 + 10'd2], mem[a3 + 10'd3]};

   logic        busy_m, done_m, err_m, mr_m, mw_m;
   logic [31:0] rdata_m, ma_m, mwd_m;
   assign busy_m  = sel ? bus3.busy            : bus1.busy;
   assign done_m  = sel ? bus3.done            : bus1.done;
   assign err_m   = sel ? bus3.err             : bus1.err;
   assign mr_m    = sel ? bus3.MemoryRead      : bus1.MemoryRead;
   assign mw_m    = sel ? bus3.MemoryWrite     : bus1.MemoryWrite;
   assign rdata_m = sel ? bus3.rdata           : bus1.rdata;
   assign ma_m    = sel ? bus3.MemoryAddress   : bus1.MemoryAddress;
   assign mwd_m   = sel ? bus3.MemoryWriteData : bus1.MemoryWriteData;

   always @(posedge clock) begin
      if (load_en)
         for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
      if (bus1.MemoryWrite) begin
         mem[a1]         <= bus1.MemoryWriteData[31:24];
         mem[a1 + 10'd1] <= bus1.MemoryWriteData[23:16];
         mem[a1 + 10'd2] <= bus1.MemoryWriteData[15:8];
         mem[a1 + 10'd3] <= bus1.MemoryWriteData[7:0];
      end
      if (bus3.MemoryWrite) begin
         mem[a3]         <= bus3.MemoryWriteData[31:24];
         mem[a3 + 10'd1] <= bus3.MemoryWriteData[23:16];
         mem[a3 + 10'd2] <= bus3.MemoryWriteData[15:8];
         mem[a3 + 10'd3] <= bus3.MemoryWriteData[7:0];
      end
   end

   // Reference: byte-wise big-endian access on ref_mem, latency from the documented edge counts.
   function automatic void model(input logic w, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] d, input int lat,
                                 output logic e, output int edge_n, output int rdc,
                                 output int wrc, output logic [31:0] val);
      int          n;
      int          base;
      longint      wa;
      logic [31:0] v;
      n    = (o[1:0] == 2'd0) ? 1 : (o[1:0] == 2'd1) ? 2 : 4;
      wa   = longint'({a[31:2], 2'b00});
      base = int'(a[9:0]);
      e = (o == 3'd3) || (o == 3'd6) || (o == 3'd7) || (n == 2 && a[0]) ||
          (n == 4 && a[1:0] != 2'b00) || (wa + 3 >= 1024);
      val = 32'd0;
      if (e) begin
         edge_n = 1; rdc = 0; wrc = 0;
         return;
      end
      if (!w) begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[base + i]);
         if (!o[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
         val = v; edge_n = lat + 1; rdc = lat; wrc = 0;
      end else begin
         for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(d >> (8 * (n - 1 - i)));
         base = int'(wa);
         val = {ref_mem[base], ref_mem[base + 1], ref_mem[base + 2], ref_mem[base + 3]};
         edge_n = (n == 4) ? 2 : lat + 2; rdc = (n == 4) ? 0 : lat; wrc = 1;
      end
   endfunction

   task automatic sync_mem();
      load_en = 1'b1;
      @(posedge clock); @(negedge clock);
      load_en = 1'b0;
   endtask

   // Drives one request from a negedge with the unit idle; returns idle at a negedge.
   task automatic issue(input logic s, input logic w, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] d);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      ob.done_edge = -1; ob.err = 1'b0; ob.rdata = 32'd0; ob.rdc = 0; ob.wrc = 0;
      ob.both = 0; ob.addr_bad = 0; ob.busy_bad = 0; ob.wdat = 32'd0;
      sel = s; write = w; op = o; addr = a; wdata = d; req = 1'b1;
      @(posedge clock);
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (!busy_m) ob.busy_bad++;
         if (mr_m) begin ob.rdc++; if (ma_m !== wa) ob.addr_bad++; end
         if (mw_m) begin ob.wrc++; ob.wdat = mwd_m; if (ma_m !== wa) ob.addr_bad++; end
         if (mr_m && mw_m) ob.both++;
         if (done_m) begin
            ob.done_edge = k + 1; ob.err = err_m; ob.rdata = rdata_m;
            break;
         end
         @(posedge clock);
      end
      req = 1'b0;
      @(posedge clock); @(negedge clock);
   endtask

   task automatic run(input logic s, input logic w, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] d);
      model(w, o, a, d, s ? 3 : 1, x_err, x_edge, x_rdc, x_wrc, x_val);
      if (!w && !x_err) exp_rdata[s] = x_val;
      issue(s, w, o, a, d);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
      ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h33; ref_mem[19] = 8'h44;
      exp_rdata[0] = 32'd0; exp_rdata[1] = 32'd0;
      @(negedge clock);
      sync_mem();
      @(posedge clock); @(negedge clock);
      n_checks++;
      if ({bus1.busy, bus1.done, bus1.err, bus1.MemoryRead, bus1.MemoryWrite} !== 5'b0) begin
         n_errors++; $display("FAIL reset_ctl1: got %b, want 00000",
            {bus1.busy, bus1.done, bus1.err, bus1.MemoryRead, bus1.MemoryWrite});
      end
      n_checks++;
      if ({bus1.rdata, bus1.MemoryAddress, bus1.MemoryWriteData} !== 96'd0) begin
         n_errors++; $display("FAIL reset_dat1: got %h, want 0",
            {bus1.rdata, bus1.MemoryAddress, bus1.MemoryWriteData});
      end
      n_checks++;
      if ({bus3.busy, bus3.done, bus3.err, bus3.MemoryRead, bus3.MemoryWrite} !== 5'b0) begin
         n_errors++; $display("FAIL reset_ctl3: got %b, want 00000",
            {bus3.busy, bus3.done, bus3.err, bus3.MemoryRead, bus3.MemoryWrite});
      end
      n_checks++;
      if ({bus3.rdata, bus3.MemoryAddress, bus3.MemoryWriteData} !== 96'd0) begin
         n_errors++; $display("FAIL reset_dat3: got %h, want 0",
            {bus3.rdata, bus3.MemoryAddress, bus3.MemoryWriteData});
      end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_loads();
      logic [2:0]  t_op  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
      logic [31:0] t_adr [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
      logic [31:0] t_exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_3380, 32'h0000_1122};
      run(1'b0, 1'b0, 3'd2, 32'h10, 32'd0);
      n_checks++;
      if (ob.done_edge !== 2 || ob.err !== 1'b0) begin
         n_errors++; $display("FAIL lw_timing: edge %0d err %b, want edge 2 err 0", ob.done_edge, ob.err);
      end
      n_checks++;
      if (ob.rdata !== 32'h1122_3344) begin
         n_errors++; $display("FAIL lw_data: got %h, want 11223344", ob.rdata);
      end
      n_checks++;
      if (ob.rdc !== 1 || ob.addr_bad !== 0) begin
         n_errors++; $display("FAIL lw_read: %0d read cycles %0d bad addr, want 1 and 0", ob.rdc, ob.addr_bad);
      end
      ref_mem[19] = 8'h80;
      sync_mem();
      for (int i = 0; i < 4; i++) begin
         run(1'b0, 1'b0, t_op[i], t_adr[i], 32'd0);
         n_checks++;
         if (ob.rdata !== t_exp[i] || ob.err !== 1'b0) begin
            n_errors++; $display("FAIL subword_load%0d: got %h err %b, want %h err 0", i, ob.rdata, ob.err, t_exp[i]);
         end
      end
      ref_mem[19] = 8'h44;
      sync_mem();
   endtask

   task automatic test_stores();
      run(1'b0, 1'b1, 3'd0, 32'h11, 32'h0000_00AA);
      n_checks++;
      if (ob.wdat !== 32'h11AA_3344 || ob.rdc !== 1 || ob.wrc !== 1 || ob.done_edge !== 3) begin
         n_errors++; $display("FAIL sb: wdat %h rd %0d wr %0d edge %0d, want 11aa3344 1 1 3",
            ob.wdat, ob.rdc, ob.wrc, ob.done_edge);
      end
      run(1'b0, 1'b1, 3'd1, 32'h12, 32'h0000_BEEF);
      n_checks++;
      if (ob.wdat !== 32'h11AA_BEEF || ob.done_edge !== 3) begin
         n_errors++; $display("FAIL sh: wdat %h edge %0d, want 11aabeef 3", ob.wdat, ob.done_edge);
      end
      n_checks++;
      if ({mem[16], mem[17], mem[18], mem[19]} !== 32'h11AA_BEEF) begin
         n_errors++; $display("FAIL sh_mem: got %h, want 11aabeef", {mem[16], mem[17], mem[18], mem[19]});
      end
      run(1'b0, 1'b1, 3'd2, 32'h20, 32'hCAFE_F00D);
      n_checks++;
      if (ob.wdat !== 32'hCAFE_F00D || ob.rdc !== 0 || ob.wrc !== 1 || ob.done_edge !== 2) begin
         n_errors++; $display("FAIL sw: wdat %h rd %0d wr %0d edge %0d, want cafef00d 0 1 2",
            ob.wdat, ob.rdc, ob.wrc, ob.done_edge);
      end
   endtask

   task automatic test_errors();
      logic        t_w   [3] = '{1'b0, 1'b1, 1'b0};
      logic [2:0]  t_op  [3] = '{3'd1, 3'd2, 3'd3};
      logic [31:0] t_adr [3] = '{32'h11, 32'h12, 32'h10};
      for (int i = 0; i < 3; i++) begin
         run(1'b0, t_w[i], t_op[i], t_adr[i], 32'h1234_5678);
         n_checks++;
         if (ob.done_edge !== 1 || ob.err !== 1'b1 || ob.rdc + ob.wrc !== 0 || ob.rdata !== 32'h0000_1122) begin
            n_errors++; $display("FAIL reject%0d: edge %0d err %b strobes %0d rdata %h, want 1 1 0 00001122",
               i, ob.done_edge, ob.err, ob.rdc + ob.wrc, ob.rdata);
         end
      end
   endtask

   task automatic test_range_latency();
      run(1'b0, 1'b0, 3'd2, 32'h3FC, 32'd0);
      n_checks++;
      if (ob.err !== 1'b0 || ob.done_edge !== 2 || ob.rdata !== x_val) begin
         n_errors++; $display("FAIL lw_top: err %b edge %0d rdata %h, want 0 2 %h", ob.err, ob.done_edge, ob.rdata, x_val);
      end
      run(1'b0, 1'b0, 3'd2, 32'h400, 32'd0);
      n_checks++;
      if (ob.err !== 1'b1 || ob.done_edge !== 1 || ob.rdc !== 0) begin
         n_errors++; $display("FAIL lw_oob: err %b edge %0d rd %0d, want 1 1 0", ob.err, ob.done_edge, ob.rdc);
      end
      run(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
      n_checks++;
      if (ob.rdc !== 3 || ob.done_edge !== 4 || ob.rdata !== 32'h11AA_BEEF) begin
         n_errors++; $display("FAIL lw_lat3: rd %0d edge %0d rdata %h, want 3 4 11aabeef", ob.rdc, ob.done_edge, ob.rdata);
      end
      run(1'b1, 1'b1, 3'd0, 32'h30, 32'h0000_0077);
      n_checks++;
      if (ob.rdc !== 3 || ob.wrc !== 1 || ob.done_edge !== 5 || ob.wdat !== x_val) begin
         n_errors++; $display("FAIL sb_lat3: rd %0d wr %0d edge %0d wdat %h, want 3 1 5 %h",
            ob.rdc, ob.wrc, ob.done_edge, ob.wdat, x_val);
      end
   endtask

   // With req held high, a new request is taken on the second edge after each done.
   task automatic test_back_to_back();
      int bad;
      sel = 1'b0; write = 1'b0; op = 3'd2; addr = 32'h10; wdata = 32'd0; req = 1'b1;
      bad = 0;
      for (int k = 0; k < 9; k++) begin
         @(posedge clock); @(negedge clock);
         if (done_m !== ((k % 3) == 1)) bad++;
         if (done_m && rdata_m !== 32'h11AA_BEEF) bad++;
      end
      req = 1'b0;
      @(posedge clock); @(negedge clock);
      exp_rdata[0] = 32'h11AA_BEEF;
      n_checks++;
      if (bad !== 0) begin
         n_errors++; $display("FAIL b2b_load: %0d cycles wrong, want 0", bad);
      end
      op = 3'd3; req = 1'b1; bad = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); @(negedge clock);
         if (done_m !== ((k % 2) == 0)) bad++;
         if (done_m && err_m !== 1'b1) bad++;
      end
      req = 1'b0;
      @(posedge clock); @(negedge clock);
      n_checks++;
      if (bad !== 0 || rdata_m !== 32'h11AA_BEEF) begin
         n_errors++; $display("FAIL b2b_err: %0d cycles wrong rdata %h, want 0 11aabeef", bad, rdata_m);
      end
   endtask

   task automatic test_busy_ignore();
      int          dn;
      logic [31:0] r;
      logic        e;
      dn = 0; r = 32'd0; e = 1'b1;
      sel = 1'b1; write = 1'b0; op = 3'd2; addr = 32'h10; req = 1'b1;
      @(posedge clock); @(negedge clock);
      req = 1'b0;
      @(posedge clock); @(negedge clock);
      op = 3'd3; addr = 32'h13; req = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (done_m) begin
            dn++;
            if (dn == 1) begin r = rdata_m; e = err_m; end
            req = 1'b0;
         end
         @(posedge clock); @(negedge clock);
      end
      req = 1'b0;
      exp_rdata[1] = 32'h11AA_BEEF;
      n_checks++;
      if (dn !== 1 || r !== 32'h11AA_BEEF || e !== 1'b0) begin
         n_errors++; $display("FAIL busy_ignore: %0d dones rdata %h err %b, want 1 11aabeef 0", dn, r, e);
      end
   endtask

   task automatic test_reset_abort();
      int wr, dn;
      sel = 1'b1; write = 1'b1; op = 3'd0; addr = 32'h10; wdata = 32'h5A; req = 1'b1;
      @(posedge clock); @(negedge clock);
      n_checks++;
      if (mr_m !== 1'b1) begin
         n_errors++; $display("FAIL abort_inread: MemoryRead %b, want 1", mr_m);
      end
      reset_n = 1'b0; req = 1'b0;
      @(posedge clock); @(negedge clock);
      n_checks++;
      if (busy_m !== 1'b0 || mr_m !== 1'b0) begin
         n_errors++; $display("FAIL abort_drop: busy %b MemoryRead %b, want 0 0", busy_m, mr_m);
      end
      reset_n = 1'b1;
      wr = 0; dn = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clock); @(negedge clock);
         wr += int'(mw_m); dn += int'(done_m);
      end
      n_checks++;
      if (wr !== 0 || dn !== 0) begin
         n_errors++; $display("FAIL abort_quiet: %0d writes %0d dones, want 0 0", wr, dn);
      end
      n_checks++;
      if ({mem[16], mem[17], mem[18], mem[19]} !== {ref_mem[16], ref_mem[17], ref_mem[18], ref_mem[19]}) begin
         n_errors++; $display("FAIL abort_mem: got %h, want %h", {mem[16], mem[17], mem[18], mem[19]},
            {ref_mem[16], ref_mem[17], ref_mem[18], ref_mem[19]});
      end
      exp_rdata[0] = 32'd0; exp_rdata[1] = 32'd0;
      n_checks++;
      if (bus1.rdata !== 32'd0 || bus3.rdata !== 32'd0) begin
         n_errors++; $display("FAIL abort_rdata: got %h %h, want 0 0", bus1.rdata, bus3.rdata);
      end
   endtask

   task automatic test_random();
      logic        s, w;
      logic [2:0]  o;
      logic [31:0] a, d;
      int          bad;
      for (int it = 0; it < 80; it++) begin
         s = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         o = 3'($urandom_range(0, 7));
         d = $urandom;
         case ($urandom_range(0, 3))
            0:       a = $urandom;
            1:       a = 32'h3F8 + $urandom_range(0, 15);
            default: a = $urandom_range(0, 1023);
         endcase
         run(s, w, o, a, d);
         n_checks++;
         if (ob.done_edge !== x_edge || ob.err !== x_err) begin
            n_errors++; $display("FAIL rnd%0d_done: edge %0d err %b, want %0d %b", it, ob.done_edge, ob.err, x_edge, x_err);
         end
         n_checks++;
         if (ob.rdata !== exp_rdata[s]) begin
            n_errors++; $display("FAIL rnd%0d_rdata: got %h, want %h", it, ob.rdata, exp_rdata[s]);
         end
         n_checks++;
         if (ob.rdc !== x_rdc || ob.wrc !== x_wrc) begin
            n_errors++; $display("FAIL rnd%0d_strobes: rd %0d wr %0d, want %0d %0d", it, ob.rdc, ob.wrc, x_rdc, x_wrc);
         end
         bad = ob.both + ob.addr_bad + ob.busy_bad;
         n_checks++;
         if (bad !== 0) begin
            n_errors++; $display("FAIL rnd%0d_bus: %0d overlap/addr/busy faults, want 0", it, bad);
         end
         if (w && !x_err) begin
            n_checks++;
            if (ob.wdat !== x_val) begin
               n_errors++; $display("FAIL rnd%0d_wdata: got %h, want %h", it, ob.wdat, x_val);
            end
         end
      end
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
      n_checks++;
      if (bad !== 0) begin
         n_errors++; $display("FAIL rnd_memory: %0d bytes differ, want 0", bad);
      end
   endtask

   initial begin
      reset_n = 1'b0; req = 1'b0; write = 1'b0; sel = 1'b0; load_en = 1'b0;
      op = 3'd0; addr = 32'd0; wdata = 32'd0;
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_range_latency();
      test_back_to_back();
      test_busy_ignore();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
